// File: rtl/miner_core_msa_stream.sv
// Streaming SHA-2 message scheduler. Loads one 16-word block and emits
// W[0..ROUNDS-1] one word per accepted handshake. Only a rolling 16-word
// window is kept: win[0] is always W[t], win[15] is W[t+15].
module miner_core_msa_stream #(
  parameter  int WORD_W = 32,
  parameter  int ROUNDS = 64,
  localparam int IDX_W  = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [16*WORD_W-1:0] chunk,
  input  logic                 chunk_valid,
  output logic                 chunk_ready,
  input  logic                 abort,
  output logic [WORD_W-1:0]    w_out,
  output logic [IDX_W-1:0]     w_idx,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic                 done
);

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
    $error("miner_core_msa_stream: WORD_W must be 32 or 64");
  end
  if (ROUNDS < 16 || ROUNDS > 127) begin : g_bad_rounds
    $error("miner_core_msa_stream: ROUNDS must be in 16..127");
  end

  // Rotate/shift amounts for the small sigmas; 64-bit selects the SHA-512 set.
  localparam int unsigned S0_A = (WORD_W == 64) ? 1  : 7;
  localparam int unsigned S0_B = (WORD_W == 64) ? 8  : 18;
  localparam int unsigned S0_C = (WORD_W == 64) ? 7  : 3;
  localparam int unsigned S1_A = (WORD_W == 64) ? 19 : 17;
  localparam int unsigned S1_B = (WORD_W == 64) ? 61 : 19;
  localparam int unsigned S1_C = (WORD_W == 64) ? 6  : 10;

  typedef enum logic {IDLE, RUN} state_e;

  state_e                   state_q;
  logic [15:0][WORD_W-1:0]  win_q;
  logic [15:0][WORD_W-1:0]  chunk_w;
  logic [IDX_W-1:0]         t_q;
  logic                     w_valid_q;
  logic                     done_q;
  logic [WORD_W-1:0]        new_w_d;
  logic                     last;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                              input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return rotr(x, S0_A) ^ rotr(x, S0_B) ^ (x >> S0_C);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return rotr(x, S1_A) ^ rotr(x, S1_B) ^ (x >> S1_C);
  endfunction

  // Word 0 sits in the top slice of the chunk bus; reorder so index i is word i.
  for (genvar gi = 0; gi < 16; gi++) begin : g_chunk
    assign chunk_w[gi] = chunk[(16-gi)*WORD_W-1 -: WORD_W];
  end

  // Next schedule word W[t+16]; computed on every accept, even when unused.
  always_comb begin
    new_w_d = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
  end

  assign last = (t_q == IDX_W'(ROUNDS - 1));

  // Scheduler FSM: load in IDLE, shift the window on each accept in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      win_q     <= '0;
      t_q       <= '0;
      w_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (chunk_valid) begin
            win_q     <= chunk_w;
            t_q       <= '0;
            w_valid_q <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            // Abort wins over a simultaneous accept: nothing is consumed.
            state_q   <= IDLE;
            w_valid_q <= 1'b0;
            t_q       <= '0;
          end else if (w_ready) begin
            win_q <= {new_w_d, win_q[15:1]};
            if (last) begin
              state_q   <= IDLE;
              w_valid_q <= 1'b0;
              done_q    <= 1'b1;
              t_q       <= '0;
            end else begin
              t_q <= t_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          w_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign chunk_ready = (state_q == IDLE) && !rst;
  assign w_out       = win_q[0];
  assign w_idx       = t_q;
  assign w_valid     = w_valid_q;
  assign done        = done_q;

endmodule

// File: tb/tb_miner_core_msa_stream.sv
// Scoreboard bench: drivers push expected words at load time, negedge
// monitors pop and compare on every accepted handshake.
module tb_miner_core_msa_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // SHA-256 instance
  logic         rst_a, cv_a, ab_a, wr_a, cr_a, wv_a, dn_a;
  logic [511:0] ch_a;
  logic [31:0]  wo_a;
  logic [6:0]   wi_a;
  // SHA-512 instance
  logic          rst_b, cv_b, ab_b, wr_b, cr_b, wv_b, dn_b;
  logic [1023:0] ch_b;
  logic [63:0]   wo_b;
  logic [6:0]    wi_b;

  miner_core_msa_stream #(.WORD_W(32), .ROUNDS(64)) dut_a (
    .clk(clk), .rst(rst_a), .chunk(ch_a), .chunk_valid(cv_a), .chunk_ready(cr_a),
    .abort(ab_a), .w_out(wo_a), .w_idx(wi_a), .w_valid(wv_a), .w_ready(wr_a), .done(dn_a));

  miner_core_msa_stream #(.WORD_W(64), .ROUNDS(80)) dut_b (
    .clk(clk), .rst(rst_b), .chunk(ch_b), .chunk_valid(cv_b), .chunk_ready(cr_b),
    .abort(ab_b), .w_out(wo_b), .w_idx(wi_b), .w_valid(wv_b), .w_ready(wr_b), .done(dn_b));

  localparam logic [511:0]  ABC32 = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [1023:0] ABC64 = {64'h6162638000000000, 896'h0, 64'h18};

  typedef struct {logic [63:0] w; int idx;} exp_t;
  exp_t qa[$];
  exp_t qb[$];

  int checks = 0, errors = 0;
  int acc_a = 0, acc_b = 0, dn_cnt_a = 0, dn_cnt_b = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] r64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference schedule over a full W[] array; hand values override for "abc".
  task automatic push_a(input logic [511:0] blk);
    logic [31:0] w [0:63];
    exp_t e;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = blk[511-32*t -: 32];
      else w[t] = (r32(w[t-2], 17) ^ r32(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                + (r32(w[t-15], 7) ^ r32(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    end
    if (blk == ABC32) begin
      w[16] = 32'h61626380;
      w[17] = 32'h000F0000;
      w[18] = 32'h7DA86405;
    end
    for (int t = 0; t < 64; t++) begin
      e.w = {32'h0, w[t]};
      e.idx = t;
      qa.push_back(e);
    end
  endtask

  task automatic push_b(input logic [1023:0] blk);
    logic [63:0] w [0:79];
    exp_t e;
    for (int t = 0; t < 80; t++) begin
      if (t < 16) w[t] = blk[1023-64*t -: 64];
      else w[t] = (r64(w[t-2], 19) ^ r64(w[t-2], 61) ^ (w[t-2] >> 6)) + w[t-7]
                + (r64(w[t-15], 1) ^ r64(w[t-15], 8) ^ (w[t-15] >> 7)) + w[t-16];
    end
    if (blk == ABC64) begin
      w[16] = 64'h6162638000000000;
      w[17] = 64'h00030000000000C0;
    end
    for (int t = 0; t < 80; t++) begin
      e.w = w[t];
      e.idx = t;
      qb.push_back(e);
    end
  endtask

  // Monitor A: scoreboard pop on accept, stall hold, done timing.
  bit fin_a = 0, stall_a = 0;
  logic [31:0] hw_a = '0;
  logic [6:0]  hi_a = '0;
  always @(negedge clk) begin : mon_a
    exp_t e;
    bit acc;
    acc = !rst_a && wv_a && wr_a && !ab_a;
    chk("done_a", {63'h0, dn_a}, {63'h0, fin_a});
    if (dn_a) begin
      dn_cnt_a++;
      chk("ready_at_done_a", {63'h0, cr_a}, 64'h1);
    end
    if (stall_a && wv_a && !rst_a) begin
      chk("hold_w_a", {32'h0, wo_a}, {32'h0, hw_a});
      chk("hold_idx_a", {57'h0, wi_a}, {57'h0, hi_a});
    end
    if (acc) begin
      if (qa.size() == 0) fail_now("extra_word_a");
      else begin
        e = qa.pop_front();
        chk("w_a", {32'h0, wo_a}, e.w);
        chk("idx_a", {57'h0, wi_a}, 64'(e.idx));
        acc_a++;
      end
    end
    fin_a   = acc && (wi_a == 7'd63);
    stall_a = wv_a && !wr_a && !rst_a && !ab_a;
    hw_a    = wo_a;
    hi_a    = wi_a;
  end

  // Monitor B: scoreboard pop on accept and done timing.
  bit fin_b = 0;
  always @(negedge clk) begin : mon_b
    exp_t e;
    bit acc;
    acc = !rst_b && wv_b && wr_b && !ab_b;
    chk("done_b", {63'h0, dn_b}, {63'h0, fin_b});
    if (dn_b) dn_cnt_b++;
    if (acc) begin
      if (qb.size() == 0) fail_now("extra_word_b");
      else begin
        e = qb.pop_front();
        chk("w_b", wo_b, e.w);
        chk("idx_b", {57'h0, wi_b}, 64'(e.idx));
        acc_b++;
      end
    end
    fin_b = acc && (wi_b == 7'd79);
  end

  task automatic load_a(input logic [511:0] blk, input bit keep);
    for (int k = 0; k < 50 && !cr_a; k++) tick();
    if (!cr_a) fail_now("timeout_ready_a");
    ch_a = blk;
    cv_a = 1'b1;
    push_a(blk);
    chk("pre_load_wv_a", {63'h0, wv_a}, 64'h0);
    tick();
    if (!keep) cv_a = 1'b0;
    chk("load_lat_wv_a", {63'h0, wv_a}, 64'h1);
    chk("load_idx_a", {57'h0, wi_a}, 64'h0);
  endtask

  task automatic wait_done_a(input int bound, input bit rnd);
    bit seen;
    seen = 0;
    for (int k = 0; k < bound; k++) begin
      tick();
      if (dn_a) begin seen = 1; break; end
      if (rnd) wr_a = 1'($urandom_range(0, 1));
    end
    if (!seen) fail_now("timeout_done_a");
  endtask

  task automatic wait_idx_a(input logic [6:0] idx);
    for (int k = 0; k < 200 && wi_a != idx; k++) tick();
    if (wi_a != idx) fail_now("timeout_idx_a");
  endtask

  initial begin
    logic [511:0] blkb;
    rst_a = 1; cv_a = 0; ab_a = 0; wr_a = 0; ch_a = '0;
    rst_b = 1; cv_b = 0; ab_b = 0; wr_b = 0; ch_b = '0;
    for (int i = 0; i < 16; i++) blkb[511-32*i -: 32] = 32'h1000_0000 + 32'(i);

    // Reset state
    tick();
    chk("rst_wv_a", {63'h0, wv_a}, 64'h0);
    chk("rst_wo_a", {32'h0, wo_a}, 64'h0);
    chk("rst_wi_a", {57'h0, wi_a}, 64'h0);
    chk("rst_done_a", {63'h0, dn_a}, 64'h0);
    chk("rst_cr_a", {63'h0, cr_a}, 64'h0);
    chk("rst_cr_b", {63'h0, cr_b}, 64'h0);
    tick();
    rst_a = 0; rst_b = 0;
    #1;
    chk("idle_cr_a", {63'h0, cr_a}, 64'h1);

    // 1: abc, w_ready tied high
    acc_a = 0; dn_cnt_a = 0; wr_a = 1;
    load_a(ABC32, 0);
    wait_done_a(200, 0);
    chk("s1_cr_done", {63'h0, cr_a}, 64'h1);
    chk("s1_wv_done", {63'h0, wv_a}, 64'h0);
    tick(); tick();
    chk("s1_accepts", 64'(acc_a), 64'd64);
    chk("s1_dones", 64'(dn_cnt_a), 64'd1);
    chk("s1_q_empty", 64'(qa.size()), 64'd0);

    // 2: same block, random ready
    acc_a = 0; dn_cnt_a = 0;
    load_a(ABC32, 0);
    wr_a = 1'($urandom_range(0, 1));
    wait_done_a(1000, 1);
    wr_a = 1;
    tick(); tick();
    chk("s2_accepts", 64'(acc_a), 64'd64);
    chk("s2_dones", 64'(dn_cnt_a), 64'd1);
    chk("s2_q_empty", 64'(qa.size()), 64'd0);

    // 4: abort at t=20 together with w_ready, then clean restart
    acc_a = 0; dn_cnt_a = 0; wr_a = 1;
    load_a(ABC32, 0);
    wait_idx_a(7'd20);
    ab_a = 1;
    tick();
    ab_a = 0;
    chk("s4_wv", {63'h0, wv_a}, 64'h0);
    chk("s4_done", {63'h0, dn_a}, 64'h0);
    chk("s4_cr", {63'h0, cr_a}, 64'h1);
    chk("s4_accepts", 64'(acc_a), 64'd20);
    qa.delete();
    tick(); tick();
    chk("s4_no_done", 64'(dn_cnt_a), 64'd0);
    acc_a = 0;
    load_a(ABC32, 0);
    wait_done_a(200, 0);
    tick(); tick();
    chk("s4_restart_accepts", 64'(acc_a), 64'd64);
    chk("s4_restart_dones", 64'(dn_cnt_a), 64'd1);

    // 5: rst mid-RUN at t=37
    acc_a = 0; dn_cnt_a = 0;
    load_a(ABC32, 0);
    wait_idx_a(7'd37);
    rst_a = 1;
    tick();
    chk("s5_wv", {63'h0, wv_a}, 64'h0);
    chk("s5_wo", {32'h0, wo_a}, 64'h0);
    chk("s5_wi", {57'h0, wi_a}, 64'h0);
    chk("s5_done", {63'h0, dn_a}, 64'h0);
    chk("s5_cr_in_rst", {63'h0, cr_a}, 64'h0);
    qa.delete();
    tick();
    chk("s5_cr_idle_rst", {63'h0, cr_a}, 64'h0);
    rst_a = 0;
    #1;
    chk("s5_cr_after", {63'h0, cr_a}, 64'h1);
    chk("s5_accepts", 64'(acc_a), 64'd37);
    chk("s5_no_done", 64'(dn_cnt_a), 64'd0);

    // 6: chunk_valid held across two blocks, chunk changes during RUN
    tick();
    acc_a = 0; dn_cnt_a = 0;
    load_a(ABC32, 1);
    ch_a = blkb;
    push_a(blkb);
    wait_done_a(200, 0);
    chk("s6_cr_bubble", {63'h0, cr_a}, 64'h1);
    chk("s6_wv_bubble", {63'h0, wv_a}, 64'h0);
    tick();
    cv_a = 0;
    chk("s6_second_wv", {63'h0, wv_a}, 64'h1);
    chk("s6_second_idx", {57'h0, wi_a}, 64'h0);
    wait_done_a(200, 0);
    tick(); tick();
    chk("s6_accepts", 64'(acc_a), 64'd128);
    chk("s6_dones", 64'(dn_cnt_a), 64'd2);
    chk("s6_q_empty", 64'(qa.size()), 64'd0);

    // 3: SHA-512 instance
    acc_b = 0; dn_cnt_b = 0; wr_b = 1;
    ch_b = ABC64; cv_b = 1;
    push_b(ABC64);
    tick();
    cv_b = 0;
    chk("s3_load_wv", {63'h0, wv_b}, 64'h1);
    begin
      bit seen;
      seen = 0;
      for (int k = 0; k < 300; k++) begin
        tick();
        if (dn_b) begin seen = 1; break; end
      end
      if (!seen) fail_now("timeout_done_b");
    end
    tick(); tick();
    chk("s3_accepts", 64'(acc_b), 64'd80);
    chk("s3_dones", 64'(dn_cnt_b), 64'd1);
    chk("s3_q_empty", 64'(qb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
